// File: rtl/screen_sequencer.sv
// Game-flow controller: title/play/win/lose sequencing, score and timer, frame-aligned screen select.
// Optional AUTO_RETURN_EN: result screens fall back to title after RESULT_FRAMES frames.
module screen_sequencer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int GAME_SECONDS   = 30,
  parameter int WIN_SCORE      = 10,
  parameter int RESULT_FRAMES  = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        start_btn,
  input  logic        hit_pulse,
  input  logic [11:0] rgb_title,
  input  logic [11:0] rgb_play,
  input  logic [11:0] rgb_win,
  input  logic [11:0] rgb_lose,
  output logic [11:0] rgb,
  output logic [1:0]  screen,
  output logic        game_active,
  output logic [6:0]  score,
  output logic [5:0]  seconds_left
);

  if (GAME_SECONDS < 1 || GAME_SECONDS > 63) begin : g_bad_secs
    $error("GAME_SECONDS out of range");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 127) begin : g_bad_score
    $error("WIN_SCORE out of range");
  end
  if (FRAMES_PER_SEC < 1 || RESULT_FRAMES < 1) begin : g_bad_frames
    $error("FRAMES_PER_SEC and RESULT_FRAMES must be positive");
  end

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_t;

  state_t        state, state_n;
  logic          vsync_q, start_q, start_req, start_req_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [6:0]    score_n, score_inc;
  logic [5:0]    seconds_n;
  logic          frame_tick, start_rise, sec_wrap;

  assign frame_tick  = vsync_q & ~vsync;
  assign start_rise  = start_btn & ~start_q;
  assign score_inc   = (score == 7'd127) ? score : score + 7'd1;
  assign sec_wrap    = frame_tick && (frame_cnt == FW'(FRAMES_PER_SEC - 1));
  assign game_active = (state == PLAY);

`ifdef AUTO_RETURN_EN
  localparam int RW = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;
  logic [RW-1:0] result_cnt, result_cnt_n;
`endif

  always_comb begin
    state_n     = state;
    score_n     = score;
    seconds_n   = seconds_left;
    frame_cnt_n = frame_cnt;
`ifdef AUTO_RETURN_EN
    result_cnt_n = result_cnt;
`endif
    case (state)
      TITLE: begin
        if (frame_tick && (start_req || start_rise)) begin
          state_n     = PLAY;
          score_n     = '0;
          seconds_n   = 6'(GAME_SECONDS);
          frame_cnt_n = '0;
        end
      end
      PLAY: begin
`ifdef AUTO_RETURN_EN
        result_cnt_n = '0;
`endif
        if (hit_pulse) score_n = score_inc;
        if (sec_wrap) begin
          frame_cnt_n = '0;
          seconds_n   = seconds_left - 6'd1;
        end else if (frame_tick) begin
          frame_cnt_n = frame_cnt + FW'(1);
        end
        // A winning hit beats a simultaneous timer expiry; the decrement still lands.
        if (hit_pulse && score_inc >= 7'(WIN_SCORE)) state_n = WIN;
        else if (sec_wrap && seconds_left == 6'd1)   state_n = LOSE;
      end
      default: begin
        if (frame_tick && start_req) state_n = TITLE;
`ifdef AUTO_RETURN_EN
        if (frame_tick) begin
          if (result_cnt == RW'(RESULT_FRAMES - 1)) state_n = TITLE;
          else result_cnt_n = result_cnt + RW'(1);
        end
`endif
      end
    endcase

    start_req_n = start_req;
    if (state_n != state)                 start_req_n = 1'b0;
    else if (state != PLAY && start_rise) start_req_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TITLE;
      vsync_q      <= 1'b1;
      start_q      <= 1'b0;
      start_req    <= 1'b0;
      frame_cnt    <= '0;
      score        <= '0;
      seconds_left <= 6'(GAME_SECONDS);
      screen       <= 2'd0;
      rgb          <= '0;
`ifdef AUTO_RETURN_EN
      result_cnt   <= '0;
`endif
    end else begin
      state        <= state_n;
      vsync_q      <= vsync;
      start_q      <= start_btn;
      start_req    <= start_req_n;
      frame_cnt    <= frame_cnt_n;
      score        <= score_n;
      seconds_left <= seconds_n;
      // Screen follows state only at frame boundaries so no frame mixes two screens.
      if (frame_tick) screen <= state;
      case (screen)
        2'd0:    rgb <= rgb_title;
        2'd1:    rgb <= rgb_play;
        2'd2:    rgb <= rgb_win;
        default: rgb <= rgb_lose;
      endcase
`ifdef AUTO_RETURN_EN
      result_cnt   <= result_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed step table, hand-written corner sequences,
// and randomized traffic compared every cycle against a game-level reference model.
module tb_screen_sequencer;
  localparam int FPS = 2, GS = 3, WS = 4, RF = 5;
  localparam int OP_CYC = 0, OP_PRESS = 1, OP_HIT = 2, OP_TICK = 3;

  logic clk = 1'b0;
  logic reset, vsync, start_btn, hit_pulse;
  logic [11:0] rgb_title, rgb_play, rgb_win, rgb_lose, rgb;
  logic [1:0]  screen;
  logic        game_active;
  logic [6:0]  score;
  logic [5:0]  seconds_left;

  int total = 0, bad = 0;
  bit chk_en = 0, vs_auto = 1, vs_man = 1;

  always #5 clk = ~clk;

  screen_sequencer #(.FRAMES_PER_SEC(FPS), .GAME_SECONDS(GS), .WIN_SCORE(WS), .RESULT_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start_btn(start_btn), .hit_pulse(hit_pulse),
    .rgb_title(rgb_title), .rgb_play(rgb_play), .rgb_win(rgb_win), .rgb_lose(rgb_lose),
    .rgb(rgb), .screen(screen), .game_active(game_active), .score(score), .seconds_left(seconds_left));

  function automatic logic [11:0] pick(int s);
    case (s)
      0: return rgb_title;
      1: return rgb_play;
      2: return rgb_win;
      default: return rgb_lose;
    endcase
  endfunction

  // Reference model: phase is the screen number, remaining time is derived from
  // the count of frames elapsed in play, score is a saturated hit count.
  bit m_vs = 1, m_st = 0, m_req = 0;
  int m_phase = 0, m_hits = 0, m_ticks = 0, m_shown = 0, m_res = 0, tick_count = 0;
  logic [11:0] m_rgb = '0;

  always @(posedge clk) begin : model
    bit tk, rs;
    int np, nh, nt;
    tk = m_vs && !vsync;
    rs = start_btn && !m_st;
    if (reset) begin
      m_vs <= 1; m_st <= 0; m_req <= 0; m_phase <= 0; m_hits <= 0;
      m_ticks <= 0; m_shown <= 0; m_res <= 0; m_rgb <= '0;
    end else begin
      np = m_phase; nh = m_hits; nt = m_ticks;
      if (m_phase == 0) begin
        if (tk && (m_req || rs)) begin np = 1; nh = 0; nt = 0; end
      end else if (m_phase == 1) begin
        if (hit_pulse) nh = (m_hits < 127) ? m_hits + 1 : 127;
        if (tk) nt = m_ticks + 1;
        if (hit_pulse && nh >= WS) np = 2;
        else if (GS - nt / FPS == 0) np = 3;
      end else begin
        if (tk && m_req) np = 0;
`ifdef AUTO_RETURN_EN
        if (tk && m_res + 1 >= RF) np = 0;
`endif
      end
      if (np != m_phase) m_res <= 0;
      else if (m_phase >= 2 && tk) m_res <= m_res + 1;
      m_req   <= (np != m_phase) ? 1'b0 : ((m_phase != 1 && rs) ? 1'b1 : m_req);
      m_vs    <= vsync;
      m_st    <= start_btn;
      m_phase <= np;
      m_hits  <= nh;
      m_ticks <= nt;
      if (tk) begin m_shown <= m_phase; tick_count <= tick_count + 1; end
      m_rgb <= pick(m_shown);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      total++;
      if (screen !== 2'(m_shown) || game_active !== (m_phase == 1) || score !== 7'(m_hits) ||
          seconds_left !== 6'(GS - m_ticks / FPS) || rgb !== m_rgb) begin
        bad++;
        $display("FAIL model_cmp t=%0t got scr=%0d act=%0d sc=%0d sec=%0d rgb=%h want scr=%0d act=%0d sc=%0d sec=%0d rgb=%h",
                 $time, screen, game_active, score, seconds_left, rgb,
                 m_shown, m_phase == 1, m_hits, GS - m_ticks / FPS, m_rgb);
      end
    end
  end

  // vsync source: falling edge every 100 clks, held low 3 cycles; or manual level.
  initial begin
    int ph;
    ph = 0;
    vsync = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 100;
      vsync = vs_auto ? !(ph >= 50 && ph < 53) : vs_man;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ticks(int n);
    int tgt, guard;
    tgt = tick_count + n;
    guard = 0;
    while (tick_count < tgt && guard < n * 100 + 300) begin cyc(); guard++; end
    if (tick_count < tgt) begin
      total++; bad++;
      $display("FAIL wait_ticks got=%0d want=%0d ticks", tick_count, tgt);
    end
  endtask

  task automatic press();
    start_btn = 1'b1;
    repeat (3) cyc();
    start_btn = 1'b0;
    cyc();
  endtask

  task automatic hits(int n);
    hit_pulse = 1'b1;
    repeat (n) cyc();
    hit_pulse = 1'b0;
  endtask

  task automatic mtick();
    vs_man = 1'b0;
    repeat (3) cyc();
    vs_man = 1'b1;
    repeat (5) cyc();
  endtask

  typedef struct {int op; int arg; int scr; int sc; int secs; int act; int sel;} vec_t;
  vec_t vq[$];

  task automatic add(int op, int arg, int scr, int sc, int secs, int act, int sel);
    vec_t v;
    v.op = op; v.arg = arg; v.scr = scr; v.sc = sc; v.secs = secs; v.act = act; v.sel = sel;
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; hit_pulse = 1'b0;
    rgb_title = 12'hA01; rgb_play = 12'hB02; rgb_win = 12'hC03; rgb_lose = 12'hD04;

    // win path
    add(OP_CYC,   1, 0, 0, 3, 0,  0);
    add(OP_PRESS, 0, 0, 0, 3, 0, -1);
    add(OP_TICK,  1, 0, 0, 3, 1, -1);
    add(OP_TICK,  1, 1, 0, 3, 1, -1);
    add(OP_CYC,   1, 1, 0, 3, 1,  1);
    add(OP_TICK,  1, 1, 0, 2, 1, -1);
    add(OP_HIT,   3, 1, 3, 2, 1, -1);
    add(OP_HIT,   1, 1, 4, 2, 0, -1);
    add(OP_HIT,   1, 1, 4, 2, 0, -1);
    add(OP_TICK,  1, 2, 4, 2, 0, -1);
    add(OP_CYC,   1, 2, 4, 2, 0,  2);
`ifdef AUTO_RETURN_EN
    add(OP_TICK,  4, 2, 4, 2, 0, -1);
    add(OP_TICK,  1, 0, 4, 2, 0, -1);
`else
    add(OP_TICK, 20, 2, 4, 2, 0, -1);
    add(OP_PRESS, 0, 2, 4, 2, 0, -1);
    add(OP_TICK,  1, 2, 4, 2, 0, -1);
    add(OP_TICK,  1, 0, 4, 2, 0, -1);
`endif
    // lose path: one second every 2 frames
    add(OP_PRESS, 0, 0, 4, 2, 0, -1);
    add(OP_TICK,  1, 0, 0, 3, 1, -1);
    add(OP_TICK,  1, 1, 0, 3, 1, -1);
    add(OP_TICK,  1, 1, 0, 2, 1, -1);
    add(OP_TICK,  1, 1, 0, 2, 1, -1);
    add(OP_TICK,  1, 1, 0, 1, 1, -1);
    add(OP_TICK,  1, 1, 0, 1, 1, -1);
    add(OP_TICK,  1, 1, 0, 0, 0, -1);
    add(OP_TICK,  1, 3, 0, 0, 0, -1);
    add(OP_CYC,   1, 3, 0, 0, 0,  3);
    add(OP_PRESS, 0, 3, 0, 0, 0, -1);
    add(OP_TICK,  1, 3, 0, 0, 0, -1);
    add(OP_TICK,  1, 0, 0, 0, 0, -1);

    cyc();
    chk_en = 1;
    repeat (2) cyc();
    chk("reset_scr", screen, 0);
    chk("reset_rgb", rgb, 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < vq.size(); i++) begin
      case (vq[i].op)
        OP_CYC:   repeat (vq[i].arg) cyc();
        OP_PRESS: press();
        OP_HIT:   hits(vq[i].arg);
        default:  wait_ticks(vq[i].arg);
      endcase
      chk($sformatf("v%0d_screen", i), screen, vq[i].scr);
      chk($sformatf("v%0d_score", i), score, vq[i].sc);
      chk($sformatf("v%0d_secs", i), seconds_left, vq[i].secs);
      chk($sformatf("v%0d_active", i), game_active, vq[i].act);
      if (vq[i].sel >= 0) chk($sformatf("v%0d_rgb", i), rgb, pick(vq[i].sel));
    end

    // reset in the middle of a game
    press();
    wait_ticks(2);
    hits(2);
    chk("mid_score", score, 2);
    chk("mid_screen", screen, 1);
    reset = 1'b1;
    cyc();
    chk("rst_score", score, 0);
    chk("rst_secs", seconds_left, GS);
    chk("rst_screen", screen, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_active", game_active, 0);
    reset = 1'b0;
    cyc();

    // winning hit on the same cycle as the final timer decrement
    vs_man = 1'b1; vs_auto = 0;
    cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    press();
    mtick();
    hits(3);
    repeat (5) mtick();
    chk("co_secs_pre", seconds_left, 1);
    vs_man = 1'b0;
    hit_pulse = 1'b1;
    cyc();
    hit_pulse = 1'b0;
    chk("co_score", score, 4);
    chk("co_secs", seconds_left, 0);
    chk("co_active", game_active, 0);
    vs_man = 1'b1;
    repeat (4) cyc();
    mtick();
    chk("co_screen", screen, 2);
    vs_auto = 1;
    reset = 1'b1; cyc(); reset = 1'b0; cyc();

    // randomized traffic against the model
    begin
      int hp;
      hp = 1;
      for (int c = 0; c < 9000; c++) begin
        if (c % 700 == 0) hp = $urandom_range(0, 3);
        rgb_title = 12'($urandom); rgb_play = 12'($urandom);
        rgb_win   = 12'($urandom); rgb_lose = 12'($urandom);
        hit_pulse = ($urandom_range(0, 99) < hp);
        if ($urandom_range(0, 149) == 0) start_btn = ~start_btn;
        reset = ($urandom_range(0, 2999) == 0);
        cyc();
      end
      reset = 1'b0; hit_pulse = 1'b0;
      cyc();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Game-flow controller for the whack-a-mole VGA front end. Sequences the title, play, win and lose screens. Counts hits and the game timer. Switches which screen renderer drives the VGA colour outputs, and changes the visible screen only at frame boundaries so no frame shows a mix of two screens. Sits between `vga_sync`, the per-screen text renderers and the board's RGB pins.

## Interface
Parameters:
- FRAMES_PER_SEC, 60, frame ticks per game-timer second
- GAME_SECONDS, 30, game duration in seconds (1..63)
- WIN_SCORE, 10, hits needed to win (1..127)
- RESULT_FRAMES, 180, frames a result screen is held before auto-return (only used with AUTO_RETURN_EN)

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- vsync  in  1  active-low vertical sync from vga_sync
- start_btn  in  1  debounced level, high while pressed
- hit_pulse  in  1  one-cycle pulse per whacked mole
- rgb_title, rgb_play, rgb_win, rgb_lose  in  12 each  {red,green,blue} from each screen renderer
- rgb  out  12  registered {red,green,blue} to the pins
- screen  out  2  displayed screen: 0 title, 1 play, 2 win, 3 lose
- game_active  out  1  high while the internal state is PLAY
- score  out  7  hit count
- seconds_left  out  6  remaining game seconds

## Operation
- Frame tick: register vsync into vsync_q (reset value 1). frame_tick = vsync_q & ~vsync, a one-cycle pulse on the vsync falling edge.
- Start edge: start_q registered. start_rise = start_btn & ~start_q. In TITLE, WIN or LOSE, start_rise sets start_req. start_req clears when the state changes. Presses during PLAY are ignored.
- TITLE:
  - on frame_tick with start_req (or start_rise in the same cycle): go to PLAY.
  - On that transition: score=0, seconds_left=GAME_SECONDS, frame_cnt=0.
- PLAY:
  - hit_pulse increments score, saturating at 127.
  - If the incremented score is >= WIN_SCORE, go to WIN in the same cycle that score updates.
  - frame_cnt counts frame_ticks from 0 to FRAMES_PER_SEC-1. On wrap, seconds_left decrements.
  - When the decrement reaches 0, go to LOSE.
  - If a win-causing hit and timer expiry occur in the same cycle, WIN has priority. The score increment is kept; seconds_left still decrements to 0.
- WIN/LOSE:
  - score and seconds_left are frozen; hit_pulse is ignored.
  - On frame_tick with start_req, go to TITLE.
- screen register: loads the state encoding only on frame_tick. Between ticks it holds, so the displayed screen lags the state by up to one frame.
- rgb: registered mux of rgb_title/play/win/lose selected by the screen register.
- Reset values: state TITLE, screen 0, rgb 0, score 0, seconds_left GAME_SECONDS, frame_cnt 0, start_req 0, game_active 0.
- Reset asserted mid-game: everything returns to reset values on the next clock edge. No partial state survives.

## Timing
- frame_tick is asserted one clk after the vsync falling edge is sampled.
- Internal state transitions are registered:
  - TITLE->PLAY occurs on the frame_tick cycle edge.
  - screen shows 1 starting at the next frame_tick.
- hit_pulse at cycle n: score and state (if a win) update at edge n+1. game_active falls at n+1. screen becomes 2 at the first frame_tick after n+1.
- rgb latency: one clk from the renderer input to the output.
- Back-to-back hit_pulse on consecutive cycles each increment score.
- A vsync held low for multiple cycles produces exactly one frame_tick.

## Configuration
- AUTO_RETURN_EN defined:
  - a result_cnt counts frame_ticks in WIN/LOSE, starting at 0 on entry.
  - When it reaches RESULT_FRAMES, the state returns to TITLE on that frame_tick.
  - A start_req still returns early.
- AUTO_RETURN_EN undefined: result_cnt is absent, and WIN/LOSE persist until start_req plus frame_tick.

## Test plan
The bench uses FRAMES_PER_SEC=2, GAME_SECONDS=3, WIN_SCORE=4, RESULT_FRAMES=5, with a vsync falling edge every 100 clks.
- Reset mid-PLAY with score=2 -> next cycle: score=0, seconds_left=3, screen=0, rgb=0, game_active=0.
- Press start in TITLE -> state PLAY at the next frame_tick. screen=1 at the following frame_tick. rgb equals rgb_play one clk after that.
- 4 hit_pulses in PLAY -> score=4, game_active=0 the cycle after the 4th pulse, and screen=2 at the next frame_tick. A 5th pulse leaves score at 4.
- No hits in PLAY -> seconds_left steps 3,2,1,0, one step every 2 frame_ticks, then state LOSE, and screen=3 at the next frame_tick.
- 4th hit coincident with the final timer decrement -> screen=2 (WIN priority), score=4, seconds_left=0.
- With AUTO_RETURN_EN, sit in WIN with no press -> screen=0 after the 5th frame_tick in WIN. Without the macro, screen stays 2 for 20 frames, then a start press returns it to 0.
